// File: rtl/fetch_inst_buffer.sv
// fetch_inst_buffer: circular fetch-to-dispatch instruction queue.
// Define FETCH_BUF_STATS_EN to add push-reject / empty-cycle stat counters.
module fetch_inst_buffer #(
   parameter int N      = 2,
   parameter int DEPTH  = 16,
   parameter int DATA_W = 32,
   parameter int ADDR_W = 32,
   parameter int CNT_W  = $clog2(DEPTH + 1),
   parameter int PC_W   = $clog2(N + 1)
) (
   input  logic                         clock,
   input  logic                         reset,
   input  logic                         flush,
   input  logic [PC_W-1:0]              push_count,
   input  logic [N-1:0][DATA_W-1:0]     push_instr,
   input  logic [N-1:0][ADDR_W-1:0]     push_pc,
   input  logic [PC_W-1:0]              dispatch_count,
   output logic [CNT_W-1:0]             free_slots,
   output logic [N-1:0][DATA_W-1:0]     ff_instr,
   output logic [ADDR_W-1:0]            ff_pc,
`ifdef FETCH_BUF_STATS_EN
   output logic [31:0]                  stat_push_reject,
   output logic [31:0]                  stat_empty_cycles,
`endif
   output logic [N-1:0]                 fetch_valid
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [PTR_W-1:0]  head;
   logic [PTR_W-1:0]  tail;
   logic [CNT_W-1:0]  count;

   logic [DATA_W-1:0] mem_instr [DEPTH];
   logic [ADDR_W-1:0] mem_pc    [DEPTH];

   logic [PC_W-1:0]   n_valid;
   logic [PC_W-1:0]   eff_pop;
   logic              push_ok;
   logic              push_do;
   logic [PC_W-1:0]   push_acc;

   // Free space is taken from registered occupancy only
   assign free_slots = CNT_W'(DEPTH) - count;

   assign push_ok  = CNT_W'(push_count) <= free_slots;
   assign push_do  = reset && !flush && push_ok;
   assign push_acc = push_do ? push_count : '0;

   // Present the oldest PC-contiguous run of up to N entries
   always_comb begin
      logic              run;
      logic [PTR_W-1:0]  idx;
      run         = 1'b1;
      idx         = head;
      fetch_valid = '0;
      ff_instr    = '0;
      for (int i = 0; i < N; i++) begin
         idx = head + PTR_W'(i);
         run = run
            && (CNT_W'(i) < count)
            && (mem_pc[idx] == mem_pc[head] + ADDR_W'(4 * i));
         fetch_valid[i] = run;
         if (run) begin
            ff_instr[i] = mem_instr[idx];
         end
      end
      ff_pc = (count != '0) ? mem_pc[head] : '0;
   end

   // Clip the dispatch request to what is actually presented
   always_comb begin
      n_valid = '0;
      for (int i = 0; i < N; i++) begin
         if (fetch_valid[i]) begin
            n_valid = n_valid + PC_W'(1);
         end
      end
      eff_pop = (dispatch_count < n_valid) ? dispatch_count : n_valid;
   end

   // Pointer and occupancy update; reset dominates flush
   always_ff @(posedge clock) begin
      if (!reset) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else if (flush) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         head  <= head + PTR_W'(eff_pop);
         tail  <= tail + PTR_W'(push_acc);
         count <= count + CNT_W'(push_acc) - CNT_W'(eff_pop);
      end
   end

   // Entry storage write; contents are never cleared
   always_ff @(posedge clock) begin
      if (push_do) begin
         for (int i = 0; i < N; i++) begin
            if (PC_W'(i) < push_count) begin
               mem_instr[tail + PTR_W'(i)] <= push_instr[i];
               mem_pc[tail + PTR_W'(i)]    <= push_pc[i];
            end
         end
      end
   end

`ifdef FETCH_BUF_STATS_EN
   logic push_rej;

   assign push_rej = !flush && (push_count != '0) && !push_ok;

   // Saturating event counters, cleared only by reset
   always_ff @(posedge clock) begin
      if (!reset) begin
         stat_push_reject  <= '0;
         stat_empty_cycles <= '0;
      end else begin
         if (push_rej && (stat_push_reject != '1)) begin
            stat_push_reject <= stat_push_reject + 32'd1;
         end
         if ((count == '0) && (stat_empty_cycles != '1)) begin
            stat_empty_cycles <= stat_empty_cycles + 32'd1;
         end
      end
   end
`else
   // No statistics hardware in this build
`endif

endmodule
